// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : axil_pkg
//  Description : Shared AXI4-Lite definitions for the command master and the
//                register bank: response codes, register offsets and the
//                command-master FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package axil_pkg;

   // AXI4-Lite response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Register bank byte offsets
   localparam logic [7:0] c_REG_CTRL = 8'h00;
   localparam logic [7:0] c_REG_DATA = 8'h04;

   // Command-master FSM state encoding
   typedef logic [2:0] axil_state_t;
   localparam axil_state_t c_ST_IDLE   = 3'd0;
   localparam axil_state_t c_ST_WR     = 3'd1;
   localparam axil_state_t c_ST_WAIT_B = 3'd2;
   localparam axil_state_t c_ST_RD     = 3'd3;
   localparam axil_state_t c_ST_WAIT_R = 3'd4;
   localparam axil_state_t c_ST_RSP    = 3'd5;

endpackage : axil_pkg
`default_nettype wire

// File: rtl/axil_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : axil_cmd_master
//  Description : Single-outstanding AXI4-Lite master. Converts a one-at-a-time
//                command/response handshake into AXI4-Lite reads and writes
//                and keeps a saturating count of non-OKAY responses.
//  Revision    : 1.0  initial release
// ============================================================================
module axil_cmd_master
   import axil_pkg::*;
#(
   parameter int ADDR_WIDTH   = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int ERRCNT_WIDTH = 8
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   // command side
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
   // response side
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      rsp_write,
   output logic [ERRCNT_WIDTH-1:0]   err_count,
   // AXI4-Lite master
   output logic [ADDR_WIDTH-1:0]     maxi_awaddr,
   output logic                      maxi_awvalid,
   input  logic                      maxi_awready,
   output logic [DATA_WIDTH-1:0]     maxi_wdata,
   output logic [DATA_WIDTH/8-1:0]   maxi_wstrb,
   output logic                      maxi_wvalid,
   input  logic                      maxi_wready,
   input  logic [1:0]                maxi_bresp,
   input  logic                      maxi_bvalid,
   output logic                      maxi_bready,
   output logic [ADDR_WIDTH-1:0]     maxi_araddr,
   output logic                      maxi_arvalid,
   input  logic                      maxi_arready,
   input  logic [DATA_WIDTH-1:0]     maxi_rdata,
   input  logic [1:0]                maxi_rresp,
   input  logic                      maxi_rvalid,
   output logic                      maxi_rready
);

   axil_state_t                r_state;
   logic [ADDR_WIDTH-1:0]      r_addr;
   logic [DATA_WIDTH-1:0]      r_wdata;
   logic [DATA_WIDTH/8-1:0]    r_wstrb;
   logic                       r_awvalid;
   logic                       r_wvalid;
   logic                       r_arvalid;
   logic                       r_aw_done;
   logic                       r_w_done;
   logic [DATA_WIDTH-1:0]      r_rsp_rdata;
   logic [1:0]                 r_rsp_resp;
   logic                       r_rsp_write;
   logic [ERRCNT_WIDTH-1:0]    r_err_count;

   logic                       w_aw_hs;
   logic                       w_w_hs;
   logic                       w_aw_fin;
   logic                       w_w_fin;
   logic                       w_b_hs;
   logic                       w_r_hs;
   logic [1:0]                 w_rsp_code;
   logic                       w_err_inc;

   // Handshake strobes; a handshake in the current cycle counts as done so
   // WR can leave in the same edge as its last channel completes.
   assign w_aw_hs    = r_awvalid & maxi_awready;
   assign w_w_hs     = r_wvalid  & maxi_wready;
   assign w_aw_fin   = r_aw_done | w_aw_hs;
   assign w_w_fin    = r_w_done  | w_w_hs;
   assign w_b_hs     = (r_state == c_ST_WAIT_B) & maxi_bvalid;
   assign w_r_hs     = (r_state == c_ST_WAIT_R) & maxi_rvalid;
   assign w_rsp_code = (r_state == c_ST_WAIT_B) ? maxi_bresp : maxi_rresp;
   assign w_err_inc  = (w_b_hs | w_r_hs) & (w_rsp_code != RESP_OKAY)
                       & (r_err_count != {ERRCNT_WIDTH{1'b1}});

   // Readies and status are pure functions of state
   assign cmd_ready    = (r_state == c_ST_IDLE);
   assign maxi_bready  = (r_state == c_ST_WAIT_B);
   assign maxi_rready  = (r_state == c_ST_WAIT_R);
   assign rsp_valid    = (r_state == c_ST_RSP);

   assign maxi_awaddr  = r_addr;
   assign maxi_araddr  = r_addr;
   assign maxi_wdata   = r_wdata;
   assign maxi_wstrb   = r_wstrb;
   assign maxi_awvalid = r_awvalid;
   assign maxi_wvalid  = r_wvalid;
   assign maxi_arvalid = r_arvalid;
   assign rsp_rdata    = r_rsp_rdata;
   assign rsp_resp     = r_rsp_resp;
   assign rsp_write    = r_rsp_write;
   assign err_count    = r_err_count;

   // Transaction FSM with its address/data and response registers
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state     <= c_ST_IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= '0;
         r_rsp_write <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (cmd_valid) begin
                  r_addr    <= cmd_addr;
                  r_wdata   <= cmd_wdata;
                  r_wstrb   <= cmd_wstrb;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  if (cmd_write) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= c_ST_WR;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= c_ST_RD;
                  end
               end
            end
            c_ST_WR: begin
               if (w_aw_hs) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (w_w_hs) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_aw_fin && w_w_fin) begin
                  r_state <= c_ST_WAIT_B;
               end
            end
            c_ST_WAIT_B: begin
               if (maxi_bvalid) begin
                  r_rsp_resp  <= maxi_bresp;
                  r_rsp_rdata <= '0;
                  r_rsp_write <= 1'b1;
                  r_state     <= c_ST_RSP;
               end
            end
            c_ST_RD: begin
               if (maxi_arready) begin
                  r_arvalid <= 1'b0;
                  r_state   <= c_ST_WAIT_R;
               end
            end
            c_ST_WAIT_R: begin
               if (maxi_rvalid) begin
                  r_rsp_resp  <= maxi_rresp;
                  r_rsp_rdata <= maxi_rdata;
                  r_rsp_write <= 1'b0;
                  r_state     <= c_ST_RSP;
               end
            end
            c_ST_RSP: begin
               if (rsp_ready) begin
                  r_state <= c_ST_IDLE;
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   // Saturating count of non-OKAY B/R responses
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_err_count <= '0;
      end else if (w_err_inc) begin
         r_err_count <= r_err_count + ERRCNT_WIDTH'(1);
      end
   end

endmodule : axil_cmd_master
`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_cmd_master
//  Description : Self-checking bench for axil_cmd_master with a register-bank
//                style slave model (CTRL at 0x0, DATA at 0x4, SLVERR elsewhere)
//                whose AW/W readiness can be delayed independently.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axil_cmd_master;

   localparam int AW = 4;
   localparam int DW = 32;
   localparam int EW = 8;
   localparam int SW = DW / 8;

   logic ACLK = 1'b0;
   logic ARESET = 1'b1;
   always #5 ACLK = ~ACLK;

   logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [SW-1:0] cmd_wstrb = '0;
   logic          rsp_valid, rsp_ready = 1'b0, rsp_write;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [EW-1:0] err_count;
   logic [AW-1:0] maxi_awaddr, maxi_araddr;
   logic          maxi_awvalid, maxi_awready, maxi_wvalid, maxi_wready;
   logic [DW-1:0] maxi_wdata, maxi_rdata;
   logic [SW-1:0] maxi_wstrb;
   logic [1:0]    maxi_bresp, maxi_rresp;
   logic          maxi_bvalid, maxi_bready, maxi_arvalid, maxi_arready;
   logic          maxi_rvalid, maxi_rready;

   int checks = 0;
   int errors = 0;

   axil_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERRCNT_WIDTH(EW)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_write(rsp_write), .err_count(err_count),
      .maxi_awaddr(maxi_awaddr), .maxi_awvalid(maxi_awvalid), .maxi_awready(maxi_awready),
      .maxi_wdata(maxi_wdata), .maxi_wstrb(maxi_wstrb), .maxi_wvalid(maxi_wvalid),
      .maxi_wready(maxi_wready), .maxi_bresp(maxi_bresp), .maxi_bvalid(maxi_bvalid),
      .maxi_bready(maxi_bready), .maxi_araddr(maxi_araddr), .maxi_arvalid(maxi_arvalid),
      .maxi_arready(maxi_arready), .maxi_rdata(maxi_rdata), .maxi_rresp(maxi_rresp),
      .maxi_rvalid(maxi_rvalid), .maxi_rready(maxi_rready)
   );

   // ---------------- slave model ----------------
   int            aw_delay = 0, w_delay = 0;
   bit            b_hold = 1'b0;
   int            aw_wait = 0, w_wait = 0;
   bit            aw_got = 1'b0, w_got = 1'b0;
   int            aw_hs_cnt = 0, w_hs_cnt = 0;
   logic [AW-1:0] s_awaddr = '0;
   logic [DW-1:0] s_wdata = '0, s_ctrl = '0, s_data = '0;
   logic [SW-1:0] s_wstrb = '0;

   assign maxi_awready = maxi_awvalid && !aw_got && (aw_wait >= aw_delay);
   assign maxi_wready  = maxi_wvalid  && !w_got  && (w_wait  >= w_delay);
   assign maxi_arready = maxi_arvalid && !maxi_rvalid;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                           input logic [DW-1:0] nw,
                                           input logic [SW-1:0] st);
      logic [DW-1:0] res;
      res = old;
      for (int b = 0; b < SW; b++)
         if (st[b]) res[8*b +: 8] = nw[8*b +: 8];
      return res;
   endfunction

   always @(posedge ACLK) begin
      if (ARESET) begin
         aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0; w_wait <= 0;
         maxi_bvalid <= 1'b0; maxi_bresp <= 2'b00;
         maxi_rvalid <= 1'b0; maxi_rresp <= 2'b00; maxi_rdata <= '0;
         s_ctrl <= '0; s_data <= '0;
      end else begin
         if (maxi_awvalid && maxi_awready) begin
            aw_got <= 1'b1; s_awaddr <= maxi_awaddr; aw_wait <= 0;
            aw_hs_cnt <= aw_hs_cnt + 1;
         end else if (maxi_awvalid && !aw_got) begin
            aw_wait <= aw_wait + 1;
         end
         if (maxi_wvalid && maxi_wready) begin
            w_got <= 1'b1; s_wdata <= maxi_wdata; s_wstrb <= maxi_wstrb; w_wait <= 0;
            w_hs_cnt <= w_hs_cnt + 1;
         end else if (maxi_wvalid && !w_got) begin
            w_wait <= w_wait + 1;
         end
         if (aw_got && w_got && !maxi_bvalid && !b_hold) begin
            if (s_awaddr == 4'h0) s_ctrl <= merge(s_ctrl, s_wdata, s_wstrb);
            if (s_awaddr == 4'h4) s_data <= merge(s_data, s_wdata, s_wstrb);
            maxi_bresp  <= (s_awaddr == 4'h0 || s_awaddr == 4'h4) ? 2'b00 : 2'b10;
            maxi_bvalid <= 1'b1;
            aw_got <= 1'b0; w_got <= 1'b0;
         end
         if (maxi_bvalid && maxi_bready) maxi_bvalid <= 1'b0;
         if (maxi_arvalid && maxi_arready) begin
            maxi_rdata  <= (maxi_araddr == 4'h0) ? s_ctrl :
                           (maxi_araddr == 4'h4) ? s_data : '0;
            maxi_rresp  <= (maxi_araddr == 4'h0 || maxi_araddr == 4'h4) ? 2'b00 : 2'b10;
            maxi_rvalid <= 1'b1;
         end
         if (maxi_rvalid && maxi_rready) maxi_rvalid <= 1'b0;
      end
   end

   // ---------------- protocol monitor (valid/payload stability) ----------------
   int            viol = 0, rsp_hs_cnt = 0;
   logic          p_rst = 1'b1;
   logic          p_awv = 0, p_awhs = 0, p_wv = 0, p_whs = 0, p_arv = 0, p_arhs = 0;
   logic          p_rspv = 0, p_rsphs = 0, p_rw = 0;
   logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
   logic [DW-1:0] p_wdata = '0, p_rdata = '0;
   logic [SW-1:0] p_wstrb = '0;
   logic [1:0]    p_resp = '0;

   always @(posedge ACLK) begin
      if (!p_rst)
         viol <= viol
            + int'(p_awv && !p_awhs && (!maxi_awvalid || maxi_awaddr !== p_awaddr))
            + int'(p_wv && !p_whs && (!maxi_wvalid || maxi_wdata !== p_wdata || maxi_wstrb !== p_wstrb))
            + int'(p_arv && !p_arhs && (!maxi_arvalid || maxi_araddr !== p_araddr))
            + int'(p_rspv && !p_rsphs && (!rsp_valid || rsp_rdata !== p_rdata
                                          || rsp_resp !== p_resp || rsp_write !== p_rw));
      if (rsp_valid && rsp_ready) rsp_hs_cnt <= rsp_hs_cnt + 1;
      p_rst <= ARESET;
      p_awv <= maxi_awvalid; p_awhs <= maxi_awvalid && maxi_awready; p_awaddr <= maxi_awaddr;
      p_wv  <= maxi_wvalid;  p_whs  <= maxi_wvalid && maxi_wready;
      p_wdata <= maxi_wdata; p_wstrb <= maxi_wstrb;
      p_arv <= maxi_arvalid; p_arhs <= maxi_arvalid && maxi_arready; p_araddr <= maxi_araddr;
      p_rspv <= rsp_valid; p_rsphs <= rsp_valid && rsp_ready;
      p_rdata <= rsp_rdata; p_resp <= rsp_resp; p_rw <= rsp_write;
   end

   // ---------------- reference model ----------------
   logic [DW-1:0] m_reg [2];
   int            m_err = 0;

   // Expected outcome of one command against a two-register bank
   task automatic model_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, output logic [DW-1:0] ex_rd,
                            output logic [1:0] ex_resp);
      bit hit;
      hit     = (a == 4'h0) || (a == 4'h4);
      ex_resp = hit ? 2'b00 : 2'b10;
      ex_rd   = '0;
      if (hit && wr) m_reg[a[2]] = merge(m_reg[a[2]], d, s);
      if (hit && !wr) ex_rd = m_reg[a[2]];
      if (!hit && m_err < 255) m_err = m_err + 1;
   endtask

   task automatic model_reset();
      m_reg[0] = '0; m_reg[1] = '0; m_err = 0;
   endtask

   // ---------------- drivers ----------------
   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, output bit ok);
      int n;
      ok = 1'b1;
      @(negedge ACLK);
      n = 0;
      while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
      if (!cmd_ready) begin
         checks++; errors++; ok = 1'b0;
         $display("FAIL cmd_ready_timeout got %b want 1", cmd_ready);
         return;
      end
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      @(negedge ACLK);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output bit ok);
      int n;
      ok = 1'b1; n = 0;
      while (!rsp_valid && n < 200) begin @(negedge ACLK); n++; end
      if (!rsp_valid) begin
         checks++; errors++; ok = 1'b0;
         $display("FAIL rsp_valid_timeout got %b want 1", rsp_valid);
      end
   endtask

   task automatic take_rsp(output logic [DW-1:0] rd, output logic [1:0] rr, output logic rw);
      rd = rsp_rdata; rr = rsp_resp; rw = rsp_write;
      rsp_ready = 1'b1;
      @(negedge ACLK);
      rsp_ready = 1'b0;
   endtask

   task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, output logic [DW-1:0] rd,
                      output logic [1:0] rr, output logic rw, output bit ok);
      issue(wr, a, d, s, ok);
      rd = '0; rr = 2'bxx; rw = 1'bx;
      if (!ok) return;
      wait_rsp(ok);
      if (!ok) return;
      take_rsp(rd, rr, rw);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      ARESET = 1'b1;
      repeat (3) @(negedge ACLK);
      ARESET = 1'b0;
      model_reset();
      checks++;
      if ({maxi_awvalid, maxi_wvalid, maxi_arvalid, maxi_bready, maxi_rready, rsp_valid} !== 6'b0) begin
         errors++; $display("FAIL reset_valids got %b want 000000",
            {maxi_awvalid, maxi_wvalid, maxi_arvalid, maxi_bready, maxi_rready, rsp_valid});
      end
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
      checks++;
      if ({rsp_rdata, rsp_resp, rsp_write, err_count} !== '0) begin
         errors++; $display("FAIL reset_rsp got %h/%b/%b/%0d want 0", rsp_rdata, rsp_resp, rsp_write, err_count);
      end
      checks++;
      if ({maxi_awaddr, maxi_araddr, maxi_wdata, maxi_wstrb} !== '0) begin
         errors++; $display("FAIL reset_addr_data got %h %h %h %h want 0", maxi_awaddr, maxi_araddr, maxi_wdata, maxi_wstrb);
      end
   endtask

   task automatic test_basic();
      logic [DW-1:0] rd, ex_rd; logic [1:0] rr, ex_rr; logic rw; bit ok;
      txn(1, 4'h4, 32'hA5A55A5A, 4'hF, rd, rr, rw, ok);
      model_txn(1, 4'h4, 32'hA5A55A5A, 4'hF, ex_rd, ex_rr);
      checks++;
      if (ok && (rr !== ex_rr || rw !== 1'b1 || rd !== 32'h0)) begin
         errors++; $display("FAIL basic_write got resp=%b write=%b rdata=%h want resp=%b write=1 rdata=0", rr, rw, rd, ex_rr);
      end
      txn(0, 4'h4, 32'h0, 4'h0, rd, rr, rw, ok);
      model_txn(0, 4'h4, 32'h0, 4'h0, ex_rd, ex_rr);
      checks++;
      if (ok && (rd !== ex_rd || rr !== ex_rr || rw !== 1'b0)) begin
         errors++; $display("FAIL basic_read got rdata=%h resp=%b write=%b want %h %b 0", rd, rr, rw, ex_rd, ex_rr);
      end
      checks++;
      if (err_count !== EW'(m_err)) begin errors++; $display("FAIL basic_errcnt got %0d want %0d", err_count, m_err); end
   endtask

   task automatic test_strobe();
      logic [DW-1:0] rd, ex_rd; logic [1:0] rr, ex_rr; logic rw; bit ok;
      txn(1, 4'h0, 32'h11223344, 4'hF, rd, rr, rw, ok);
      model_txn(1, 4'h0, 32'h11223344, 4'hF, ex_rd, ex_rr);
      txn(1, 4'h0, 32'hFFFFFFFF, 4'h5, rd, rr, rw, ok);
      model_txn(1, 4'h0, 32'hFFFFFFFF, 4'h5, ex_rd, ex_rr);
      txn(0, 4'h0, 32'h0, 4'h0, rd, rr, rw, ok);
      model_txn(0, 4'h0, 32'h0, 4'h0, ex_rd, ex_rr);
      checks++;
      if (ok && (rd !== 32'h11FF33FF || rd !== ex_rd || rr !== 2'b00)) begin
         errors++; $display("FAIL strobe_read got rdata=%h resp=%b want 11ff33ff 00", rd, rr);
      end
   endtask

   task automatic test_errors();
      logic [DW-1:0] rd, ex_rd; logic [1:0] rr, ex_rr; logic rw; bit ok;
      int e0;
      e0 = m_err;
      txn(1, 4'h8, 32'hDEADBEEF, 4'hF, rd, rr, rw, ok);
      model_txn(1, 4'h8, 32'hDEADBEEF, 4'hF, ex_rd, ex_rr);
      checks++;
      if (ok && rr !== 2'b10) begin errors++; $display("FAIL err_write_resp got %b want 10", rr); end
      txn(0, 4'hC, 32'h0, 4'h0, rd, rr, rw, ok);
      model_txn(0, 4'hC, 32'h0, 4'h0, ex_rd, ex_rr);
      checks++;
      if (ok && (rr !== 2'b10 || rd !== 32'h0)) begin
         errors++; $display("FAIL err_read got resp=%b rdata=%h want 10 0", rr, rd);
      end
      checks++;
      if (err_count !== EW'(e0 + 2)) begin errors++; $display("FAIL err_count_two got %0d want %0d", err_count, e0 + 2); end
      for (int i = 0; i < 300; i++) begin
         txn(1, 4'h8, DW'(i), 4'hF, rd, rr, rw, ok);
         model_txn(1, 4'h8, DW'(i), 4'hF, ex_rd, ex_rr);
         if (!ok) break;
      end
      checks++;
      if (err_count !== 8'd255 || m_err != 255) begin
         errors++; $display("FAIL err_count_saturate got %0d want 255", err_count);
      end
   endtask

   task automatic test_ordering();
      logic [DW-1:0] rd, ex_rd; logic [1:0] rr, ex_rr; logic rw; bit ok;
      int a0, w0, r0, v0;
      int awd [3] = '{3, 0, 0};
      int wd  [3] = '{0, 5, 0};
      for (int k = 0; k < 3; k++) begin
         aw_delay = awd[k]; w_delay = wd[k];
         a0 = aw_hs_cnt; w0 = w_hs_cnt; r0 = rsp_hs_cnt; v0 = viol;
         txn(1, 4'h4, 32'h1000_0000 + DW'(k), 4'hF, rd, rr, rw, ok);
         model_txn(1, 4'h4, 32'h1000_0000 + DW'(k), 4'hF, ex_rd, ex_rr);
         @(negedge ACLK);
         checks++;
         if (ok && (rr !== ex_rr || rw !== 1'b1)) begin
            errors++; $display("FAIL order%0d_resp got %b/%b want %b/1", k, rr, rw, ex_rr);
         end
         checks++;
         if (aw_hs_cnt - a0 != 1 || w_hs_cnt - w0 != 1) begin
            errors++; $display("FAIL order%0d_handshakes got aw=%0d w=%0d want 1 1", k, aw_hs_cnt - a0, w_hs_cnt - w0);
         end
         checks++;
         if (rsp_hs_cnt - r0 != 1 || viol != v0) begin
            errors++; $display("FAIL order%0d_stability got rsp=%0d viol=%0d want 1 0", k, rsp_hs_cnt - r0, viol - v0);
         end
      end
      aw_delay = 0; w_delay = 0;
      txn(0, 4'h4, 32'h0, 4'h0, rd, rr, rw, ok);
      model_txn(0, 4'h4, 32'h0, 4'h0, ex_rd, ex_rr);
      checks++;
      if (ok && rd !== ex_rd) begin errors++; $display("FAIL order_readback got %h want %h", rd, ex_rd); end
   endtask

   task automatic test_rsp_hold();
      logic [DW-1:0] rd, ex_rd, rd0; logic [1:0] rr, ex_rr; logic rw; bit ok;
      int bad;
      issue(0, 4'h4, 32'h0, 4'h0, ok);
      model_txn(0, 4'h4, 32'h0, 4'h0, ex_rd, ex_rr);
      if (ok) wait_rsp(ok);
      if (ok) begin
         rd0 = rsp_rdata; bad = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            if (!rsp_valid || rsp_rdata !== rd0 || cmd_ready !== 1'b0) bad++;
         end
         checks++;
         if (bad != 0) begin errors++; $display("FAIL rsp_hold got %0d bad cycles want 0", bad); end
         take_rsp(rd, rr, rw);
         checks++;
         if (rd !== ex_rd || rr !== ex_rr) begin
            errors++; $display("FAIL rsp_hold_data got %h/%b want %h/%b", rd, rr, ex_rd, ex_rr);
         end
         checks++;
         if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rsp_hold_release got ready=%b valid=%b want 1 0", cmd_ready, rsp_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] rd, ex_rd; logic [1:0] rr, ex_rr; logic rw; bit ok;
      int n;
      b_hold = 1'b1;
      issue(1, 4'h4, 32'hCAFEF00D, 4'hF, ok);
      n = 0;
      while (!maxi_bready && n < 50) begin @(negedge ACLK); n++; end
      checks++;
      if (maxi_bready !== 1'b1) begin errors++; $display("FAIL mid_reach_waitb got %b want 1", maxi_bready); end
      ARESET = 1'b1;
      @(negedge ACLK);
      ARESET = 1'b0;
      b_hold = 1'b0;
      model_reset();
      checks++;
      if ({maxi_awvalid, maxi_wvalid, maxi_arvalid, maxi_bready, maxi_rready, rsp_valid} !== 6'b0
          || cmd_ready !== 1'b1 || err_count !== 8'd0) begin
         errors++; $display("FAIL mid_reset_state got v=%b ready=%b err=%0d want 0 1 0",
            {maxi_awvalid, maxi_wvalid, maxi_arvalid, maxi_bready, maxi_rready, rsp_valid}, cmd_ready, err_count);
      end
      txn(1, 4'h4, 32'h0BADCAFE, 4'hF, rd, rr, rw, ok);
      model_txn(1, 4'h4, 32'h0BADCAFE, 4'hF, ex_rd, ex_rr);
      checks++;
      if (ok && (rr !== 2'b00 || rw !== 1'b1)) begin
         errors++; $display("FAIL mid_after_write got %b/%b want 00/1", rr, rw);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] rd, ex_rd, d; logic [1:0] rr, ex_rr; logic rw; bit ok, wr;
      logic [AW-1:0] a; logic [SW-1:0] s;
      for (int i = 0; i < 60; i++) begin
         wr = 1'($urandom_range(0, 1));
         a  = AW'($urandom_range(0, 3) * 4);
         d  = $urandom;
         s  = SW'($urandom);
         aw_delay = $urandom_range(0, 3);
         w_delay  = $urandom_range(0, 3);
         txn(wr, a, d, s, rd, rr, rw, ok);
         model_txn(wr, a, d, s, ex_rd, ex_rr);
         if (!ok) break;
         checks++;
         if (rd !== ex_rd || rr !== ex_rr || rw !== wr || err_count !== EW'(m_err)) begin
            errors++;
            $display("FAIL random%0d got rdata=%h resp=%b write=%b err=%0d want %h %b %b %0d",
                     i, rd, rr, rw, err_count, ex_rd, ex_rr, wr, m_err);
         end
      end
      aw_delay = 0; w_delay = 0;
      checks++;
      if (viol != 0) begin errors++; $display("FAIL protocol_stability got %0d violations want 0", viol); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_strobe();
      test_errors();
      test_ordering();
      test_rsp_hold();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound
   initial begin
      #2000000;
      $display("FAIL global_timeout got running want finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

endmodule : tb_axil_cmd_master
`default_nettype wire

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Single-outstanding AXI4-Lite master that turns a simple command/response handshake into AXI4-Lite transactions.
- Sits directly upstream of axil_regbank. A test sequencer or CPU-side glue issues one read or write at a time and gets back read data plus the AXI response code.
- Tracks non-OKAY responses in a saturating error counter for the bench and status logic.

Parameters:
- ADDR_WIDTH, 4, width of the command address and the AXI address.
- DATA_WIDTH, 32, data width. Must be 32 or 64; the strobe width is DATA_WIDTH/8.
- ERRCNT_WIDTH, 8, width of the saturating error counter.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when both cmd_valid and cmd_ready are high.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored on reads.
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes; ignored on reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  AXI BRESP or RRESP.
- rsp_write  out  1  echoes cmd_write of the completed command.
- err_count  out  ERRCNT_WIDTH  saturating count of non-OKAY responses.
- maxi_awaddr, maxi_awvalid out; maxi_awready in.
- maxi_wdata, maxi_wstrb, maxi_wvalid out; maxi_wready in.
- maxi_bresp in 2; maxi_bvalid in; maxi_bready out.
- maxi_araddr, maxi_arvalid out; maxi_arready in.
- maxi_rdata in; maxi_rresp in 2; maxi_rvalid in; maxi_rready out.

Behaviour:
- Reset (ARESET=1 at a clock edge):
  - state=IDLE.
  - All maxi_*valid, maxi_bready, maxi_rready, rsp_valid = 0.
  - rsp_rdata=0, rsp_resp=0, rsp_write=0, err_count=0.
  - Address and data output registers = 0.
- Mid-operation reset abandons the transaction; the downstream slave is reset in the same cycle by system convention.
- FSM states: IDLE, WR, WAIT_B, RD, WAIT_R, RSP.
- IDLE:
  - cmd_ready=1, combinational from state. cmd_ready=0 in every other state.
  - On accept, capture addr/wdata/wstrb/write into output registers.
  - Next state is WR (write) or RD (read).
- WR:
  - maxi_awvalid and maxi_wvalid assert in the cycle after accept.
  - Each drops at the edge where its own handshake completes; aw_done and w_done flags record completion.
  - AW and W may complete in either order or in the same cycle.
  - The master never deasserts a valid before its handshake.
  - Go to WAIT_B at the edge where both are done, counting a handshake occurring that same cycle.
- WAIT_B:
  - maxi_bready=1.
  - On B handshake: capture maxi_bresp into rsp_resp, set rsp_rdata=0, rsp_write=1, go to RSP.
- RD:
  - maxi_arvalid=1 until handshake; then WAIT_R.
- WAIT_R:
  - maxi_rready=1.
  - On R handshake: capture maxi_rdata and maxi_rresp, set rsp_write=0, go to RSP.
- RSP:
  - rsp_valid=1; rsp_* fields stay stable while rsp_valid is high.
  - On rsp_ready, go to IDLE.
  - A new command can be accepted no earlier than the cycle after the response handshake.
- Master latency: 1 cycle from cmd accept to AXI valid; 1 cycle from B/R handshake to rsp_valid.
- Against axil_regbank, a write takes 4 cycles from cmd accept to rsp_valid.
- B/R arriving outside its WAIT state is never accepted, since ready=0 there; it is not an error for this block.
- err_count:
  - Increments by 1 on the B or R handshake when the response is not OKAY (2'b00).
  - Holds at all-ones; no wrap.
- Address is passed through unmodified; no alignment check.

Decomposition:
- Shared package axil_pkg:
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - register offsets CTRL=0x0, DATA=0x4;
  - FSM state encoding.
- axil_regbank migrates to axil_pkg as well.
- No sub-module: one FSM plus datapath registers.

Test Plan:
- Write 0x4 / 0xA5A55A5A / strb 0xF, then read 0x4 (slave axil_regbank) -> write rsp_resp=OKAY, rsp_write=1; read rsp_rdata=0xA5A55A5A, rsp_resp=OKAY; err_count=0.
- Write 0x0 / 0x11223344 / strb 0xF, then 0x0 / 0xFFFFFFFF / strb 0x5, then read 0x0 -> rdata=0x11FF33FF.
- Write to 0x8, then read 0xC -> both rsp_resp=SLVERR; read rdata=0; err_count=2. Then 300 bad writes -> err_count=255.
- Slave BFM ordering on write to 0x4:
  - awready delayed 3 cycles, wready immediate -> single write, valids stable until each handshake, rsp_valid exactly once.
  - Repeat with wready delayed 5 cycles and awready immediate.
  - Repeat with both same-cycle.
- Read 0x4 with rsp_ready low 6 cycles -> rsp_valid held, rdata stable, cmd_ready=0 throughout; next cmd accepted only after the rsp handshake.
- ARESET pulsed 1 cycle while in WAIT_B -> next cycle all valids/readies 0, state IDLE, err_count 0, cmd_ready=1; a following write 0x4 completes OKAY.
